cla_pipe_adder: RTL and testbench

//  Parametrised, pipelined carry-lookahead adder/subtractor: generalises the 4-bit CLA to WIDTH bits.

---
 rtl/cla_pipe_adder.sv | 169 ++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder
//   Pipelined carry-lookahead adder/subtractor. The WIDTH-bit operands are cut
//   into STAGES slices of WIDTH/STAGES bits. Each slice is built from GROUP-bit
//   lookahead groups. Slice k is resolved in pipeline stage k. Its carry-out is
//   registered and becomes the carry-in of slice k+1 one cycle later.
//   Upper operand bits travel forward with the partial sum so that every field
//   of a result leaves in the same cycle. Throughput is one operation per clock.
//
//   Optional build macro: CLA_SAT_EN. When defined, the final stage saturates s
//   to the most positive or most negative value on a signed overflow.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; drops all in-flight operations
//   in_valid   a/b/c_in/sub hold an operation
//   in_ready   operation is taken this cycle (= !out_valid | out_ready)
//   a, b       WIDTH-bit operands (unsigned or two's complement)
//   c_in       carry-in, ignored when sub=1
//   sub        0: a+b+c_in   1: a-b
//   out_valid  s/c_out/ovf hold a result
//   out_ready  consumer takes the result
//   s          sum/difference modulo 2^WIDTH (saturated with CLA_SAT_EN)
//   c_out      carry out of the MSB (sub=1: 1 means no borrow)
//   ovf        signed overflow
module cla_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;

  // Returns {carry into slice MSB, carry out of slice, slice sum}.
  // Group carries are formed from group generate/propagate, so the carry
  // into each group does not ripple through the previous group's bits.
  function automatic logic [SW+1:0] cla_slice(input logic [SW-1:0] x,
                                              input logic [SW-1:0] y,
                                              input logic          ci);
    logic [SW-1:0] g;
    logic [SW-1:0] p;
    logic [SW:0]   c;
    logic          gg;
    logic          gp;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int j = 0; j < SW / GROUP; j++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
        gp = gp & p[j*GROUP+i];
        c[j*GROUP+i+1] = g[j*GROUP+i] | (p[j*GROUP+i] & c[j*GROUP+i]);
      end
      c[(j+1)*GROUP] = gg | (gp & c[j*GROUP]);
    end
    return {c[SW-1], c[SW], p ^ c[SW-1:0]};
  endfunction

`ifdef CLA_SAT_EN
  // On overflow both effective operands share a sign; that sign picks the rail.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] sum,
                                                input logic             of,
                                                input logic             a_msb);
    if (!of)
      return sum;
    else if (a_msb)
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  // Stage registers; index k holds the state after slice k has been resolved.
  logic             vld_p [STAGES];
  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic [WIDTH-1:0] s_p   [STAGES];
  logic             c_p   [STAGES];
  logic             ovf_p [STAGES];

  // Stage inputs and combinational slice results.
  logic [WIDTH-1:0] stage_a [STAGES];
  logic [WIDTH-1:0] stage_b [STAGES];
  logic [WIDTH-1:0] stage_s [STAGES];
  logic             stage_c [STAGES];
  logic [SW+1:0]    res     [STAGES];
  logic [WIDTH-1:0] nxt_s   [STAGES];
  logic             nxt_c   [STAGES];
  logic             nxt_ovf [STAGES];

  logic en;

  assign en        = !vld_p[STAGES-1] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_p[STAGES-1];
  assign s         = s_p[STAGES-1];
  assign c_out     = c_p[STAGES-1];
  assign ovf       = ovf_p[STAGES-1];

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stage_a[k] = '0;
      stage_b[k] = '0;
      stage_s[k] = '0;
      stage_c[k] = 1'b0;
      res[k]     = '0;
      nxt_s[k]   = '0;
      nxt_c[k]   = 1'b0;
      nxt_ovf[k] = 1'b0;
    end
    // Subtraction is a + ~b + 1; the forced carry-in replaces c_in.
    stage_a[0] = a;
    stage_b[0] = sub ? ~b : b;
    stage_c[0] = sub | c_in;
    for (int k = 1; k < STAGES; k++) begin
      stage_a[k] = a_p[k-1];
      stage_b[k] = b_p[k-1];
      stage_s[k] = s_p[k-1];
      stage_c[k] = c_p[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      res[k]               = cla_slice(stage_a[k][k*SW +: SW], stage_b[k][k*SW +: SW], stage_c[k]);
      nxt_s[k]             = stage_s[k];
      nxt_s[k][k*SW +: SW] = res[k][SW-1:0];
      nxt_c[k]             = res[k][SW];
      nxt_ovf[k]           = res[k][SW+1] ^ res[k][SW];
    end
`ifdef CLA_SAT_EN
    nxt_s[STAGES-1] = saturate(nxt_s[STAGES-1], nxt_ovf[STAGES-1], stage_a[STAGES-1][WIDTH-1]);
`endif
  end

  // Stage boundaries: slice k result -> register k; all stages advance together on en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) vld_p[k] <= 1'b0;
      s_p[STAGES-1]   <= '0;
      c_p[STAGES-1]   <= 1'b0;
      ovf_p[STAGES-1] <= 1'b0;
    end else if (en) begin
      vld_p[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) vld_p[k] <= vld_p[k-1];
      for (int k = 0; k < STAGES; k++) begin
        a_p[k]   <= stage_a[k];
        b_p[k]   <= stage_b[k];
        s_p[k]   <= nxt_s[k];
        c_p[k]   <= nxt_c[k];
        ovf_p[k] <= nxt_ovf[k];
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder
//   Self-checking bench for cla_pipe_adder (WIDTH=16, GROUP=4). Expected
//   results come from integer arithmetic on the operands and flow through a
//   scoreboard queue; directed operations also pin the results to literals.
module tb_cla_pipe_adder;
  parameter int STAGES = 2;
  localparam int WIDTH = 16;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sb;
  } op_t;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        c_out;
  logic        ovf;

  cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(4), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .c_out(c_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          last_stall = -1;
  int          n_popped = 0;
  exp_t        q[$];
  logic [15:0] last_s;
  logic        last_c;
  logic        last_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Result from the arithmetic meaning of the operation.
  function automatic exp_t model(input op_t op, input int acc);
    exp_t        e;
    int          sa;
    int          sbv;
    int          r;
    int unsigned ua;
    int unsigned ub;
    sa  = int'($signed(op.a));
    sbv = int'($signed(op.b));
    ua  = 32'(op.a);
    ub  = 32'(op.b);
    if (op.sb) begin
      r   = sa - sbv;
      e.c = (ua >= ub);
    end else begin
      r   = sa + sbv + int'(op.ci);
      e.c = (ua + ub + 32'(op.ci)) > 32'd65535;
    end
    e.o = (r > 32767) || (r < -32768);
    e.s = r[15:0];
`ifdef CLA_SAT_EN
    if (r > 32767) e.s = 16'h7FFF;
    else if (r < -32768) e.s = 16'h8000;
`endif
    e.acc = acc;
    return e;
  endfunction

  function automatic op_t rand_op();
    op_t         op;
    logic [15:0] ext [5];
    ext = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001};
    op.a  = ($urandom_range(0, 3) == 0) ? ext[$urandom_range(0, 4)] : 16'($urandom);
    op.b  = ($urandom_range(0, 3) == 0) ? ext[$urandom_range(0, 4)] : 16'($urandom);
    op.ci = 1'($urandom);
    op.sb = 1'($urandom);
    return op;
  endfunction

  // One clock: drive on the falling edge, check 1 ns later, record handshakes
  // that the next rising edge will complete.
  task automatic cycle(input logic iv, input op_t op, input logic ordy, output logic acc);
    exp_t h;
    @(negedge clk);
    in_valid  = iv;
    a         = op.a;
    b         = op.b;
    c_in      = op.ci;
    sub       = op.sb;
    out_ready = ordy;
    #1;
    cyc++;
    chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
    if (out_valid) begin
      if (q.size() == 0) begin
        fail_now("spurious_result");
      end else begin
        h = q[0];
        chk("result", {14'd0, s, c_out, ovf}, {14'd0, h.s, h.c, h.o});
        if (out_ready) begin
          void'(q.pop_front());
          n_popped++;
          last_s = s;
          last_c = c_out;
          last_o = ovf;
          if (last_stall < h.acc) chk("latency", 32'(cyc - h.acc), 32'(STAGES));
          else if (cyc - h.acc < STAGES) fail_now("latency_too_short");
        end else begin
          last_stall = cyc;
        end
      end
    end
    acc = in_valid && in_ready;
    if (acc) q.push_back(model(op, cyc));
  endtask

  task automatic drain();
    op_t  z;
    logic acc;
    int   k;
    z = '{16'h0, 16'h0, 1'b0, 1'b0};
    k = 0;
    while (q.size() != 0 && k < 50) begin
      cycle(1'b0, z, 1'b1, acc);
      k++;
    end
    if (q.size() != 0) fail_now("drain_timeout");
  endtask

  task automatic directed(input string name, input op_t op,
                          input logic [15:0] es, input logic ec, input logic eo);
    logic acc;
    int   k;
    k = 0;
    acc = 1'b0;
    while (!acc && k < 20) begin
      cycle(1'b1, op, 1'b1, acc);
      k++;
    end
    if (!acc) fail_now({name, "_accept_timeout"});
    drain();
    chk(name, {14'd0, last_s, last_c, last_o}, {14'd0, es, ec, eo});
  endtask

  initial begin
    op_t  op;
    op_t  z;
    logic acc;
    int   t;
    int   sent;
    int   pop0;
    z = '{16'h0, 16'h0, 1'b0, 1'b0};

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    cycle(1'b0, z, 1'b1, acc);
    cycle(1'b0, z, 1'b1, acc);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    // Directed operations with hand-computed results
    directed("add_1_0_cin", '{16'h0001, 16'h0000, 1'b1, 1'b0}, 16'h0002, 1'b0, 1'b0);
    directed("carry_chain", '{16'hFFFF, 16'h0001, 1'b0, 1'b0}, 16'h0000, 1'b1, 1'b0);
    directed("sub_neg",     '{16'hFFB0, 16'h0028, 1'b0, 1'b1}, 16'hFF88, 1'b1, 1'b0);
    directed("full_cin",    '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0}, 16'hFFFF, 1'b1, 1'b0);
    directed("sub_cin_ign", '{16'h0005, 16'h0005, 1'b1, 1'b1}, 16'h0000, 1'b1, 1'b0);
`ifdef CLA_SAT_EN
    directed("pos_ovf",     '{16'h7FFF, 16'h0001, 1'b0, 1'b0}, 16'h7FFF, 1'b0, 1'b1);
    directed("neg_ovf",     '{16'h8000, 16'h0001, 1'b0, 1'b1}, 16'h8000, 1'b1, 1'b1);
`else
    directed("pos_ovf",     '{16'h7FFF, 16'h0001, 1'b0, 1'b0}, 16'h8000, 1'b0, 1'b1);
    directed("neg_ovf",     '{16'h8000, 16'h0001, 1'b0, 1'b1}, 16'h7FFF, 1'b1, 1'b1);
`endif

    // Reset asserted with operations in flight and a result stalled at the output
    cycle(1'b1, '{16'h1111, 16'h2222, 1'b0, 1'b0}, 1'b1, acc);
    cycle(1'b1, '{16'h3333, 16'h4444, 1'b0, 1'b0}, 1'b0, acc);
    for (int i = 0; i < STAGES; i++) cycle(1'b0, z, 1'b0, acc);
    chk("inflight_valid_before_rst", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_s", 32'(s), 32'd0);
    q.delete();
    cycle(1'b0, z, 1'b1, acc);
    cycle(1'b0, z, 1'b1, acc);
    rst_n = 1'b1;
    last_stall = cyc;
    directed("after_rst", '{16'h0100, 16'h0023, 1'b0, 1'b0}, 16'h0123, 1'b0, 1'b0);

    // Six back-to-back operations with a three-cycle consumer stall
    pop0 = n_popped;
    sent = 0;
    t    = 0;
    op   = rand_op();
    while (sent < 6 && t < 40) begin
      cycle(1'b1, op, !(t >= 3 && t < 6), acc);
      if (t >= 3 && t < 6 && out_valid) chk("stall_in_ready", 32'(in_ready), 32'd0);
      if (acc) begin
        sent++;
        op = rand_op();
      end
      t++;
    end
    if (sent != 6) fail_now("stream_send_timeout");
    drain();
    chk("stream_count", 32'(n_popped - pop0), 32'd6);

    // Randomized traffic with bubbles and back-pressure
    op = rand_op();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), op, 1'($urandom_range(0, 3) != 0), acc);
      if (acc || !in_valid) op = rand_op();
    end
    // Full-rate streaming
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, op, 1'b1, acc);
      if (acc) op = rand_op();
    end
    drain();
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

endmodule
